inv_mix_columns_seq: RTL and testbench
======================================

Name: inv_mix_columns_seq

Overview:
- Sequential AES InvMixColumns stage for the decryption datapath. It accepts a 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Each output byte is the GF(2^8) sum of the four column bytes multiplied by {0e,0b,0d,09}, using the 0x1B reduction polynomial. The per-byte products come from four instances per column of the existing inverse-multiplication block.
- It sits between InvSubBytes/AddRoundKey and the next decryption round.
- It holds its result until the downstream stage accepts it.

Parameters:
- COLS_PER_CYCLE, 1, columns computed per BUSY cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  state_in is valid
- in_ready  out  1  block can accept a state
- state_in  in  128  input state; [127:120] = byte 0 (row0,col0); column c = bytes 4c..4c+3
- out_valid  out  1  state_out is valid
- out_ready  in  1  downstream accepts state_out
- state_out  out  128  InvMixColumns result, same byte ordering as state_in
- busy  out  1  high in BUSY state

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; column counter = 0.
  - Internal state register = 0; state_out = 0.
  - out_valid = 0, busy = 0, in_ready = 0 while rst_n is low.
  - in_ready = 1 from the first clock edge after rst_n deasserts.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready = 1. When in_valid & in_ready at a clock edge, capture state_in into the work register, set col = 0, go to BUSY.
  - BUSY: in_ready = 0, busy = 1. Each cycle, compute columns col .. col+COLS_PER_CYCLE-1 from the captured bytes, write the results into the result register, then col += COLS_PER_CYCLE. When the last column is written, go to DONE.
  - DONE: out_valid = 1, state_out = result register, held stable until out_valid & out_ready. On that handshake edge, go to IDLE and set out_valid = 0.
- Per-column arithmetic, for column bytes s0..s3:
  - r0 = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - r1 = 09·s0 ^ 0e·s1 ^ 0b·s2 ^ 0d·s3
  - r2 = 0d·s0 ^ 09·s1 ^ 0e·s2 ^ 0b·s3
  - r3 = 0b·s0 ^ 0d·s1 ^ 09·s2 ^ 0e·s3
  - All values are 8-bit, with no carries.
- Latency: accept edge at cycle N gives out_valid high from cycle N + 4/COLS_PER_CYCLE + 1 (5, 3 or 2 cycles).
- Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles minimum. in_ready is not asserted in DONE; no overlap.
- Boundary conditions:
  - in_valid held high during BUSY/DONE: ignored, no second capture. state_in may change freely after the accept edge without affecting the result.
  - out_ready held low in DONE: remains in DONE indefinitely, state_out and out_valid stable.
  - out_ready high with out_valid low: no effect.
  - Column counter wrap: never exceeds 3; the transition to DONE happens on the cycle that writes column 3.
  - Reset asserted mid-BUSY or in DONE: immediate return to reset values. The partial result is discarded and never presented.
  - in_valid and rst_n release in the same cycle: not accepted until in_ready is 1.

Test Plan:
- FIPS-197 column vectors, COLS_PER_CYCLE=1:
  - state_in = 8e4da1bc_9fdc589d_01010101_d5d5d7d6 -> state_out = db135345_f20a225c_01010101_d4d4d4d5.
  - out_valid rises exactly 5 cycles after the accept edge.
- Same vector with COLS_PER_CYCLE=2 and 4: identical state_out, latency 3 and 2 cycles respectively.
- Identity/fixed points:
  - state_in = c6c6c6c6 repeated ×4 -> same value out.
  - state_in = 0 -> 0.
  - state_in = 4d7ebdf8 repeated ×4 -> 2d26314c repeated ×4.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE: out_valid stays 1, state_out stable, in_ready stays 0, a second in_valid pulse is not captured.
  - Release out_ready: IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 two cycles into BUSY -> out_valid=0, state_out=0, busy=0 immediately (asynchronous). After release, a new vector gives a correct, uncorrupted result.
- Back-to-back with random states against a software InvMixColumns model: every accepted state yields exactly one output, in order, with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/inv_mix_columns_seq.sv
// Per-byte GF(2^8) products {09,0b,0d,0e} of one state byte, 0x1B reduction.
// Latency: combinational.
// Backpressure: none, pure function of its input.
module inv_mul_bytes (
    input  logic [7:0] a,
    output logic [7:0] m09,
    output logic [7:0] m0b,
    output logic [7:0] m0d,
    output logic [7:0] m0e
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] x2, x4, x8;

    assign x2  = xt(a);
    assign x4  = xt(x2);
    assign x8  = xt(x4);
    assign m09 = x8 ^ a;
    assign m0b = x8 ^ x2 ^ a;
    assign m0d = x8 ^ x4 ^ a;
    assign m0e = x8 ^ x4 ^ x2;
endmodule

// Sequential AES InvMixColumns, COLS_PER_CYCLE columns per BUSY cycle.
// Latency: 4/COLS_PER_CYCLE BUSY cycles after the accept edge, then DONE.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module inv_mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // STEP wraps to 0 for 4 columns per cycle, so col stays at 0 there.
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

    fsm_t         state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         rdy_en_q;
    logic [127:0] work_q;
    logic [31:0]  res_q   [4];
    logic [31:0]  wcol    [4];
    logic [31:0]  col_res [COLS_PER_CYCLE];
    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic         accept;

    assign in_ready  = rdy_en_q && (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign state_out = {res_q[0], res_q[1], res_q[2], res_q[3]};

    for (genvar c = 0; c < 4; c++) begin : g_wcol
        assign wcol[c] = work_q[127 - 32*c -: 32];
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        logic [7:0] s   [4];
        logic [7:0] p09 [4];
        logic [7:0] p0b [4];
        logic [7:0] p0d [4];
        logic [7:0] p0e [4];

        assign col_idx[k] = col_q + 2'(k);

        for (genvar b = 0; b < 4; b++) begin : g_byte
            assign s[b] = wcol[col_idx[k]][31 - 8*b -: 8];
            inv_mul_bytes u_mul (
                .a   (s[b]),
                .m09 (p09[b]),
                .m0b (p0b[b]),
                .m0d (p0d[b]),
                .m0e (p0e[b])
            );
        end

        assign col_res[k] = {p0e[0] ^ p0b[1] ^ p0d[2] ^ p09[3],
                             p09[0] ^ p0e[1] ^ p0b[2] ^ p0d[3],
                             p0d[0] ^ p09[1] ^ p0e[2] ^ p0b[3],
                             p0b[0] ^ p0d[1] ^ p09[2] ^ p0e[3]};
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    col_d   = '0;
                end
            end
            BUSY: begin
                if (col_q == LAST) begin
                    state_d = DONE;
                    col_d   = '0;
                end else begin
                    col_d = col_q + STEP;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                col_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            col_q    <= '0;
            rdy_en_q <= 1'b0;
            work_q   <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            rdy_en_q <= 1'b1;
            if (accept) work_q <= state_in;
            if (state_q == BUSY) begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) res_q[col_idx[k]] <= col_res[k];
            end
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq at 1, 2 and 4 columns per cycle.
module tb_inv_mix_columns_seq;
    logic         clk;
    logic         rst_n;
    logic         iv    [3];
    logic         ir    [3];
    logic [127:0] sin   [3];
    logic         ov    [3];
    logic         ordy  [3];
    logic [127:0] sout  [3];
    logic         bz    [3];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .state_in  (sin[g]),
            .out_valid (ov[g]),
            .out_ready (ordy[g]),
            .state_out (sout[g]),
            .busy      (bz[g])
        );
    end

    typedef struct {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] imc(input logic [127:0] st);
        logic [7:0]   coef [4];
        logic [7:0]   s    [4];
        logic [7:0]   acc;
        logic [127:0] r = '0;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) s[k] = st[127 - 8*(4*c + k) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(coef[(k - row + 4) % 4], s[k]);
                r[127 - 8*(4*c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Presents v to instance i, waits for the result, then completes the handshake.
    task automatic run_vec(input int i, input logic [127:0] v,
                           output logic [127:0] res, output int lat);
        int guard = 0;
        @(negedge clk);
        iv[i] = 1'b1; sin[i] = v; ordy[i] = 1'b0;
        while (!ir[i] && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) chk("accept_timeout", 128'd0, 128'd1);
        @(posedge clk);
        @(negedge clk);
        iv[i] = 1'b0; sin[i] = {$urandom, $urandom, $urandom, $urandom};
        lat = 1;
        while (!ov[i] && lat < 30) begin @(negedge clk); lat++; end
        res = sout[i];
        ordy[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ordy[i] = 1'b0;
    endtask

    task automatic rand_stream(input int i, input int n);
        logic [127:0] q [$];
        int got = 0;
        fork
            begin
                logic [127:0] v;
                int guard;
                for (int t = 0; t < n; t++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    v = {$urandom, $urandom, $urandom, $urandom};
                    iv[i] = 1'b1; sin[i] = v; guard = 0;
                    while (!ir[i] && guard < 100) begin @(negedge clk); guard++; end
                    if (guard >= 100) chk("rand_accept_timeout", 128'd0, 128'd1);
                    q.push_back(imc(v));
                    @(negedge clk);
                    iv[i] = 1'b0; sin[i] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            begin
                int guard = 0;
                while (got < n && guard < 5000) begin
                    @(negedge clk); guard++;
                    ordy[i] = ($urandom_range(0, 2) != 0);
                    if (ov[i] && ordy[i]) begin
                        if (q.size() == 0) chk("rand_unexpected_output", sout[i], 128'hx);
                        else chk("rand_result", sout[i], q.pop_front());
                        got++;
                    end
                end
                @(negedge clk);
                ordy[i] = 1'b0;
                chk("rand_output_count", 128'(got), 128'(n));
            end
        join
        chk("rand_queue_empty", 128'(q.size()), 128'd0);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] FIPS_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

    initial begin
        vec_t         tbl [4];
        logic [127:0] res;
        int           lat;

        tbl[0] = '{FIPS_IN, FIPS_OUT};
        tbl[1] = '{{4{32'hc6c6c6c6}}, {4{32'hc6c6c6c6}}};
        tbl[2] = '{128'd0, 128'd0};
        tbl[3] = '{{4{32'h4d7ebdf8}}, {4{32'h2d26314c}}};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; sin[i] = '0;
        end
        #12;
        chk("reset_ctrl", {125'd0, ir[0], ov[0], bz[0]}, 128'd0);
        chk("reset_state_out", sout[0], 128'd0);

        // in_valid already high when reset releases: no capture until in_ready.
        @(negedge clk);
        iv[0] = 1'b1; sin[0] = FIPS_IN; rst_n = 1'b1;
        #1 chk("release_in_ready_low", {127'd0, ir[0]}, 128'd0);
        @(negedge clk);
        chk("release_no_capture", {126'd0, ir[0], bz[0]}, 128'd2);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious out_ready in IDLE has no effect.
        ordy[0] = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_out_ready", {126'd0, ov[0], ir[0]}, 128'd1);
        ordy[0] = 1'b0;

        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 4; v++) begin
                run_vec(i, tbl[v].din, res, lat);
                chk($sformatf("vec%0d_cpc%0d", v, 1 << i), res, tbl[v].dexp);
                chk($sformatf("lat%0d_cpc%0d", v, 1 << i), 128'(lat), 128'(4 / (1 << i) + 1));
            end
        end

        // Backpressure: hold DONE for 10 cycles while a second request is offered.
        @(negedge clk);
        iv[0] = 1'b1; sin[0] = FIPS_IN;
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0; sin[0] = {4{32'hc6c6c6c6}};
        repeat (4) @(negedge clk);
        chk("bp_done_reached", {127'd0, ov[0]}, 128'd1);
        for (int c = 0; c < 10; c++) begin
            iv[0] = c[0];
            chk($sformatf("bp_hold_%0d", c), {ov[0], ir[0], sout[0]}, {1'b1, 1'b0, FIPS_OUT});
            @(negedge clk);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        chk("bp_release", {126'd0, ov[0], ir[0]}, 128'd1);
        repeat (3) @(negedge clk);
        chk("bp_no_second_capture", {126'd0, bz[0], ov[0]}, 128'd0);

        // Asynchronous reset two cycles into BUSY.
        @(negedge clk);
        iv[0] = 1'b1; sin[0] = {4{32'h4d7ebdf8}};
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        chk("mid_busy", {127'd0, bz[0]}, 128'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_ctrl", {126'd0, ov[0], bz[0]}, 128'd0);
        chk("async_reset_state_out", sout[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_reset_idle", {126'd0, ov[0], bz[0]}, 128'd0);
        run_vec(0, FIPS_IN, res, lat);
        chk("after_reset_result", res, FIPS_OUT);

        for (int i = 0; i < 3; i++) rand_stream(i, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
